riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter_pkg.sv | 22 ++
 rtl/riscv_arb_rr2.sv | 29 ++
 rtl/riscv_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter: default bus
// widths, wait-counter width, requester bit positions and FSM state encoding.
package riscv_mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    // Wait counter width; bounds the legal TIMEOUT range to 2..255.
    localparam int unsigned CNT_W = 8;

    // Bit positions of each requester in the picker request/grant vectors.
    localparam int unsigned REQ_INST = 0;
    localparam int unsigned REQ_DATA = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StInst = 2'd1,
        StData = 2'd2
    } arb_state_e;

endpackage

// File: rtl/riscv_arb_rr2.sv
// riscv_arb_rr2
// Two-way round-robin picker, purely combinational.
// Ports:
//   req   [1:0]  requests, bit REQ_INST = instruction, bit REQ_DATA = data
//   last         1 when the data side won the previous grant
//   grant [1:0]  one-hot grant (all zero when nothing requests)
module riscv_arb_rr2
    import riscv_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[REQ_INST] && req[REQ_DATA]) begin
            // Conflict: favour whichever side did not win last time.
            if (last) begin
                grant[REQ_INST] = 1'b1;
            end else begin
                grant[REQ_DATA] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Arbitrates one shared memory port between the instruction fetch and the
// load/store requesters. One owner at a time, round-robin on conflict, with a
// wait-cycle timeout that aborts a stuck access and pulses err_o.
// Ports:
//   clk, rst                         clock, async active-high reset
//   inst_ce_i/inst_addr_i            instruction read request
//   inst_o/inst_busy_o               instruction data, stall while pending
//   data_ce_i/data_we_i/data_addr_i/data_i   data request
//   data_o/data_busy_o               load data, stall while pending
//   mem_ce_o/mem_we_o/mem_addr_o/mem_wdata_o shared memory request
//   mem_rdata_i/mem_ready_i          memory read data, completion strobe
//   err_o                            one-cycle pulse on timeout abort
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ce_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_busy_o,
    input  logic              data_ce_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_busy_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q;
    logic              last_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] inst_hold_q;
    logic [DATA_W-1:0] data_hold_q;

    logic       own_inst;
    logic       own_data;
    logic       owned;
    logic       abort;
    logic       done;
    logic       decide;
    logic [1:0] req;
    logic [1:0] grant;

    assign own_inst = (state_q == StInst);
    assign own_data = (state_q == StData);
    assign owned    = own_inst | own_data;

    // Abort in the owned cycle where the counter already sits at TIMEOUT-1.
    assign abort  = owned & ~mem_ready_i & (cnt_q == CntLast);
    assign done   = owned & (mem_ready_i | abort);
    // Regrant from IDLE or on any completion so ownerships run back-to-back.
    assign decide = ~owned | done;

    assign req[REQ_INST] = inst_ce_i;
    assign req[REQ_DATA] = data_ce_i;

    riscv_arb_rr2 u_rr2 (
        .req   (req),
        .last  (last_data_q),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_data_q <= 1'b0;
            cnt_q       <= '0;
            inst_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            if (decide) begin
                cnt_q <= '0;
                if (grant[REQ_DATA]) begin
                    state_q     <= StData;
                    last_data_q <= 1'b1;
                end else if (grant[REQ_INST]) begin
                    state_q     <= StInst;
                    last_data_q <= 1'b0;
                end else begin
                    state_q <= StIdle;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (own_inst && mem_ready_i) begin
                inst_hold_q <= mem_rdata_i;
            end
            if (own_data && mem_ready_i && !data_we_i) begin
                data_hold_q <= mem_rdata_i;
            end
        end
    end

    assign mem_ce_o = owned;
    assign mem_we_o = own_data & data_we_i;
    assign err_o    = abort;

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (own_inst) begin
            mem_addr_o = inst_addr_i;
        end else if (own_data) begin
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_i;
        end
    end

    assign inst_busy_o = inst_ce_i & ~(own_inst & done);
    assign data_busy_o = data_ce_i & ~(own_data & done);

    // Read data bypasses the hold register in the completion cycle.
    assign inst_o = (own_inst && mem_ready_i) ? mem_rdata_i : inst_hold_q;
    assign data_o = (own_data && mem_ready_i && !data_we_i) ? mem_rdata_i : data_hold_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
// Directed bench for riscv_mem_arbiter: expected completions are queued when a
// request is set up and popped when the arbiter completes it.
module tb_riscv_mem_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_ce_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic [DATA_W-1:0] inst_o;
    logic              inst_busy_o;
    logic              data_ce_i;
    logic              data_we_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              data_busy_o;
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;
    logic              err_o;

    riscv_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_ce_i   (inst_ce_i),
        .inst_addr_i (inst_addr_i),
        .inst_o      (inst_o),
        .inst_busy_o (inst_busy_o),
        .data_ce_i   (data_ce_i),
        .data_we_i   (data_we_i),
        .data_addr_i (data_addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .data_busy_o (data_busy_o),
        .mem_ce_o    (mem_ce_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic [31:0] exp_out;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input bit is_data, input logic [31:0] addr, input logic [31:0] exp_out);
        exp_t e;
        e.is_data = is_data;
        e.addr    = addr;
        e.exp_out = exp_out;
        sb.push_back(e);
    endtask

    // Called in a cycle where the bench drives a completion.
    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_pending"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_mem_ce"}, 32'(mem_ce_o), 32'd1);
        check({tag, "_addr"}, mem_addr_o, e.addr);
        if (e.is_data) begin
            check({tag, "_data_busy"}, 32'(data_busy_o), 32'd0);
            check({tag, "_inst_busy"}, 32'(inst_busy_o), 32'(inst_ce_i));
            check({tag, "_data_o"}, data_o, e.exp_out);
        end else begin
            check({tag, "_inst_busy"}, 32'(inst_busy_o), 32'd0);
            check({tag, "_data_busy"}, 32'(data_busy_o), 32'(data_ce_i));
            check({tag, "_inst_o"}, inst_o, e.exp_out);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        settle();
        check("rst_mem_ce", 32'(mem_ce_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_inst_busy", 32'(inst_busy_o), 32'(inst_ce_i));
        check("rst_data_busy", 32'(data_busy_o), 32'(data_ce_i));
        cyc();
        cyc();
    endtask

    // Leaves the bench in the first cycle after the earliest possible grant.
    task automatic release_reset();
        rst = 1'b0;
        settle();
        check("rel_no_early_grant", 32'(mem_ce_o), 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        inst_ce_i   = 1'b0;
        inst_addr_i = '0;
        data_ce_i   = 1'b0;
        data_we_i   = 1'b0;
        data_addr_i = '0;
        data_i      = '0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b0;
        #1;
        check("reset_mem_ce", 32'(mem_ce_o), 32'd0);
        check("reset_mem_we", 32'(mem_we_o), 32'd0);
        check("reset_mem_wdata", mem_wdata_o, 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_inst_o", inst_o, 32'd0);
        check("reset_data_o", data_o, 32'd0);
        check("reset_inst_busy", 32'(inst_busy_o), 32'd0);
        check("reset_data_busy", 32'(data_busy_o), 32'd0);

        // Instruction-only fetch, ready in the first owned cycle.
        cyc();
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h100;
        settle();
        check("a_busy_in_reset", 32'(inst_busy_o), 32'd1);
        check("a_mem_ce_in_reset", 32'(mem_ce_o), 32'd0);
        release_reset();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h0050_0093;
        push(1'b0, 32'h100, 32'h0050_0093);
        settle();
        check("a_mem_we", 32'(mem_we_o), 32'd0);
        pop_check("a_fetch");
        cyc();
        mem_ready_i = 1'b0;
        inst_ce_i   = 1'b0;
        settle();
        check("a_inst_hold", inst_o, 32'h0050_0093);
        apply_reset();

        // Simultaneous requests after reset: data first, instruction with no gap.
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h100;
        data_ce_i   = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h2000;
        release_reset();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        push(1'b1, 32'h2000, 32'h1111_2222);
        settle();
        pop_check("b_data_first");
        cyc();
        data_ce_i   = 1'b0;
        mem_rdata_i = 32'h3333_4444;
        push(1'b0, 32'h100, 32'h3333_4444);
        settle();
        pop_check("b_inst_next");
        check("b_data_hold", data_o, 32'h1111_2222);
        cyc();
        inst_ce_i   = 1'b0;
        mem_ready_i = 1'b0;
        settle();
        check("b_inst_hold", inst_o, 32'h3333_4444);
        apply_reset();

        // Load, then a store that must leave the load data in place.
        data_ce_i   = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h2000;
        release_reset();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h5A5A_0001;
        push(1'b1, 32'h2000, 32'h5A5A_0001);
        settle();
        pop_check("c_load");
        cyc();
        data_we_i   = 1'b1;
        data_addr_i = 32'h2004;
        data_i      = 32'hDEAD_BEEF;
        mem_ready_i = 1'b0;
        settle();
        check("c_st_we", 32'(mem_we_o), 32'd1);
        check("c_st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check("c_st_addr", mem_addr_o, 32'h2004);
        check("c_st_busy", 32'(data_busy_o), 32'd1);
        cyc();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        push(1'b1, 32'h2004, 32'h5A5A_0001);
        settle();
        pop_check("c_store");
        check("c_st_we_done", 32'(mem_we_o), 32'd1);
        cyc();
        data_ce_i   = 1'b0;
        data_we_i   = 1'b0;
        mem_ready_i = 1'b0;
        settle();
        check("c_hold_after_store", data_o, 32'h5A5A_0001);
        apply_reset();

        // Both held high with ready every cycle: strict alternation.
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h100;
        data_ce_i   = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            push((k % 2) == 0, ((k % 2) == 0) ? 32'h2000 : 32'h100, 32'hA000_0000 + 32'(k));
        end
        release_reset();
        for (int k = 0; k < 6; k++) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = 32'hA000_0000 + 32'(k);
            settle();
            pop_check($sformatf("d_xfer%0d", k));
            cyc();
        end
        mem_ready_i = 1'b0;
        apply_reset();

        // Memory never ready: abort in the TIMEOUT-th owned cycle.
        release_reset();
        for (int i = 1; i <= 16; i++) begin
            settle();
            check($sformatf("e_err_c%0d", i), 32'(err_o), 32'(i == 16));
            check($sformatf("e_busy_c%0d", i), 32'(data_busy_o), 32'(i != 16));
            check($sformatf("e_addr_c%0d", i), mem_addr_o, 32'h2000);
            if (i == 16) check("e_hold_kept", data_o, 32'd0);
            cyc();
        end
        settle();
        check("e_next_inst_addr", mem_addr_o, 32'h100);
        check("e_next_mem_ce", 32'(mem_ce_o), 32'd1);
        check("e_err_one_cycle", 32'(err_o), 32'd0);
        check("e_inst_busy", 32'(inst_busy_o), 32'd1);
        apply_reset();

        // Reset mid-data access, then data wins the next conflict again.
        release_reset();
        cyc();
        settle();
        check("f_mem_ce_before", 32'(mem_ce_o), 32'd1);
        check("f_addr_before", mem_addr_o, 32'h2000);
        apply_reset();
        release_reset();
        settle();
        check("f_regrant_data", mem_addr_o, 32'h2000);
        check("f_regrant_ce", 32'(mem_ce_o), 32'd1);

        inst_ce_i = 1'b0;
        data_ce_i = 1'b0;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
